// File: rtl/mode_switch_sequencer_if.sv
// Mode switch sequencer bus: mode requests in, datapath control out.
// The sequencer takes the slave side; the selector/datapath the master side.
interface mode_switch_sequencer_if;
    logic [2:0]  current_mode;
    logic        mode_change;
    logic        pipe_idle;
    logic        clr_done;
    logic        pipe_halt;
    logic        buf_clr;
    logic        cfg_we;
    logic        cfg_addr;
    logic [15:0] cfg_data;
    logic        pipe_start;
    logic [2:0]  active_mode;
    logic        busy;
    logic        timeout_err;

    modport master (
        output current_mode,
        output mode_change,
        output pipe_idle,
        output clr_done,
        input  pipe_halt,
        input  buf_clr,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        input  pipe_start,
        input  active_mode,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  current_mode,
        input  mode_change,
        input  pipe_idle,
        input  clr_done,
        output pipe_halt,
        output buf_clr,
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        output pipe_start,
        output active_mode,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/mode_switch_sequencer.sv
// Halts, clears, reconfigures and restarts the analyzer datapath on
// every mode change; runs a mode-0 boot sequence after reset release.
module mode_switch_sequencer #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mode_switch_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_CLR_REQ,
        S_CLR_WAIT,
        S_CFG0,
        S_CFG1,
        S_START
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       target_q, target_d;
    logic [2:0]       pend_mode_q, pend_mode_d;
    logic             pend_vld_q, pend_vld_d;
    logic             terr_q, terr_d;

    logic             halt_q;
    logic             clr_q;
    logic             we_q;
    logic             addr_q;
    logic [15:0]      data_q;
    logic             start_q;
    logic [2:0]       amode_q;
    logic             busy_q;

    logic             req_ok;
    logic             cnt_hit;
    logic             take_pend;
    logic             entry;
    logic             waiting;
    logic [15:0]      data_d;

    // Enable mask written as config word 0 for each mode.
    function automatic logic [15:0] word0(input logic [2:0] m);
        logic [15:0] w;
        w = 16'h0000;
        unique case (1'b1)
            (m == 3'd0): w = 16'h0003;
            (m == 3'd1): w = 16'h0005;
            (m == 3'd2): w = 16'h0009;
            (m == 3'd3): w = 16'h0013;
            (m == 3'd4): w = 16'h0023;
            (m == 3'd5): w = 16'h0040;
            default:     w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next-state, target/pending bookkeeping and ack-wait counter.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        pend_mode_d = pend_mode_q;
        pend_vld_d  = pend_vld_q;
        terr_d      = terr_q;
        take_pend   = 1'b0;
        req_ok      = bus.mode_change && (bus.current_mode <= 3'd5);
        cnt_hit     = (cnt_q == CNT_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (pend_vld_q) begin
                    take_pend = 1'b1;
                    state_d   = S_HALT;
                end else if (req_ok) begin
                    target_d  = bus.current_mode;
                    state_d   = S_HALT;
                end
            end
            S_HALT: begin
                if (bus.pipe_idle) begin
                    state_d = S_CLR_REQ;
                end else if (cnt_hit) begin
                    state_d = S_CLR_REQ;
                    terr_d  = 1'b1;
                end
            end
            S_CLR_REQ: state_d = S_CLR_WAIT;
            S_CLR_WAIT: begin
                if (bus.clr_done) begin
                    state_d = S_CFG0;
                end else if (cnt_hit) begin
                    state_d = S_CFG0;
                    terr_d  = 1'b1;
                end
            end
            S_CFG0: state_d = S_CFG1;
            S_CFG1: state_d = S_START;
            S_START: begin
                if (pend_vld_q) begin
                    take_pend = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_pend) begin
            target_d   = pend_mode_q;
            pend_vld_d = 1'b0;
        end

        // A request that cannot start now is queued; latest one wins.
        if (req_ok && (state_q != S_IDLE || pend_vld_q)) begin
            pend_mode_d = bus.current_mode;
            pend_vld_d  = 1'b1;
        end

        entry = (state_d != state_q);
        if (entry && state_d == S_HALT) begin
            terr_d = 1'b0;
        end

        waiting = (state_q == S_HALT) || (state_q == S_CLR_WAIT);
        if (entry || !waiting) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_d)
            S_CFG0:  data_d = word0(target_d);
            S_CFG1:  data_d = {13'd0, target_d} + 16'd1;
            default: data_d = 16'h0000;
        endcase
    end

    // State, bookkeeping and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            target_q    <= 3'd0;
            pend_mode_q <= 3'd0;
            pend_vld_q  <= 1'b1;
            terr_q      <= 1'b0;
            halt_q      <= 1'b0;
            clr_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 1'b0;
            data_q      <= 16'h0000;
            start_q     <= 1'b0;
            amode_q     <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            pend_mode_q <= pend_mode_d;
            pend_vld_q  <= pend_vld_d;
            terr_q      <= terr_d;
            halt_q      <= (state_d == S_HALT) ||
                           (state_d == S_CLR_REQ) ||
                           (state_d == S_CLR_WAIT) ||
                           (state_d == S_CFG0) ||
                           (state_d == S_CFG1);
            clr_q       <= (state_d == S_CLR_REQ);
            we_q        <= (state_d == S_CFG0) || (state_d == S_CFG1);
            addr_q      <= (state_d == S_CFG1);
            data_q      <= data_d;
            start_q     <= (state_d == S_START);
            busy_q      <= (state_d != S_IDLE);
            if (state_d == S_START) begin
                amode_q <= target_d;
            end
        end
    end

    assign bus.pipe_halt   = halt_q;
    assign bus.buf_clr     = clr_q;
    assign bus.cfg_we      = we_q;
    assign bus.cfg_addr    = addr_q;
    assign bus.cfg_data    = data_q;
    assign bus.pipe_start  = start_q;
    assign bus.active_mode = amode_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Scoreboard bench for mode_switch_sequencer: expected strobe events are
// queued by stimulus and checked by a separate negedge monitor.
module tb_mode_switch_sequencer;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [2:0]  mode;
        logic        terr;
    } ev_t;

    logic clk;
    logic rst_n;
    ev_t  sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    mode_switch_sequencer_if bus ();

    mode_switch_sequencer #(
        .TIMEOUT_CYC(16),
        .CNT_W      (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word0(input logic [2:0] m);
        logic [15:0] w;
        case (m)
            3'd0:    w = 16'h0003;
            3'd1:    w = 16'h0005;
            3'd2:    w = 16'h0009;
            3'd3:    w = 16'h0013;
            3'd4:    w = 16'h0023;
            3'd5:    w = 16'h0040;
            default: w = 16'hxxxx;
        endcase
        return w;
    endfunction

    task automatic push_seq(input logic [2:0] m, input logic terr);
        sb.push_back('{kind: 0, data: 16'h0000, mode: 3'd0, terr: 1'b0});
        sb.push_back('{kind: 1, data: exp_word0(m), mode: 3'd0, terr: 1'b0});
        sb.push_back('{kind: 2, data: {13'd0, m} + 16'd1, mode: 3'd0, terr: 1'b0});
        sb.push_back('{kind: 3, data: 16'h0000, mode: m, terr: terr});
    endtask

    task automatic req(input logic [2:0] m);
        @(negedge clk);
        bus.current_mode = m;
        bus.mode_change  = 1'b1;
        @(negedge clk);
        bus.mode_change  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.busy || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(n < 300), 32'd1);
    endtask

    function automatic logic [25:0] all_outs();
        return {bus.pipe_halt, bus.buf_clr, bus.cfg_we, bus.cfg_addr,
                bus.cfg_data, bus.pipe_start, bus.active_mode, bus.busy,
                bus.timeout_err};
    endfunction

    // Monitor: pop and compare whenever the DUT presents a strobe.
    initial begin
        int   k;
        int   nstb;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.buf_clr || bus.cfg_we || bus.pipe_start)) begin
                nstb = int'(bus.buf_clr) + int'(bus.cfg_we) + int'(bus.pipe_start);
                check("strobe_onehot", nstb, 1);
                k = bus.buf_clr ? 0 : (bus.cfg_we ? (bus.cfg_addr ? 2 : 1) : 3);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got kind %0d expected none", k);
                end else begin
                    e = sb.pop_front();
                    check("ev_kind", k, e.kind);
                    if (k == 1 || k == 2) begin
                        check("cfg_data", bus.cfg_data, e.data);
                    end
                    if (k == 3) begin
                        check("start_mode", bus.active_mode, e.mode);
                        check("start_terr", bus.timeout_err, e.terr);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        bus.current_mode = 3'd0;
        bus.mode_change  = 1'b0;
        bus.pipe_idle    = 1'b1;
        bus.clr_done     = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(all_outs()), 32'd0);

        // Boot sequence for mode 0.
        push_seq(3'd0, 1'b0);
        rst_n = 1'b1;
        n = 0;
        while (!bus.pipe_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("boot_latency", n, 6);
        wait_idle("boot");
        check("boot_terr", bus.timeout_err, 1'b0);

        // Mode 3 with acks high: exact latency and busy window.
        push_seq(3'd3, 1'b0);
        req(3'd3);
        acc = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            acc += int'(bus.busy);
        end
        check("m3_busy_cnt", acc, 6);
        check("m3_start", {bus.pipe_start, bus.active_mode}, {1'b1, 3'd3});
        @(negedge clk);
        check("m3_idle", bus.busy, 1'b0);
        wait_idle("m3");

        // pipe_idle stuck low: HALT times out after 16 cycles.
        bus.pipe_idle = 1'b0;
        push_seq(3'd1, 1'b1);
        req(3'd1);
        n = 1;
        while (!bus.buf_clr && n < 100) begin
            @(negedge clk);
            if (!bus.buf_clr) n++;
        end
        check("halt_timeout_len", n, 16);
        check("halt_terr_set", bus.timeout_err, 1'b1);
        bus.pipe_idle = 1'b1;
        wait_idle("tmo");
        check("terr_sticky", bus.timeout_err, 1'b1);

        // Clean sequence clears the error on HALT entry.
        push_seq(3'd2, 1'b0);
        req(3'd2);
        check("terr_clear", {bus.pipe_halt, bus.timeout_err}, {1'b1, 1'b0});
        wait_idle("m2");

        // clr_done stuck low: CLR_WAIT times out.
        bus.clr_done = 1'b0;
        push_seq(3'd4, 1'b1);
        req(3'd4);
        wait_idle("clrtmo");
        bus.clr_done = 1'b1;

        // Requests 4 then 2 during mode 1: only 2 is applied next.
        push_seq(3'd1, 1'b0);
        push_seq(3'd2, 1'b0);
        req(3'd1);
        n = 0;
        while (!(bus.cfg_we && !bus.cfg_addr) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_cfg0", 32'(n < 50), 32'd1);
        bus.current_mode = 3'd4;
        bus.mode_change  = 1'b1;
        @(negedge clk);
        bus.current_mode = 3'd2;
        @(negedge clk);
        bus.mode_change  = 1'b0;
        wait_idle("pend");
        check("pend_mode", bus.active_mode, 3'd2);

        // Invalid modes 6 and 7 are ignored.
        req(3'd6);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc += int'(bus.busy) + int'(bus.pipe_halt);
        end
        req(3'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc += int'(bus.busy) + int'(bus.pipe_halt);
        end
        check("inv_mode_quiet", acc, 0);
        check("inv_mode_keep", bus.active_mode, 3'd2);

        // Mode 5 requested during START is queued.
        push_seq(3'd0, 1'b0);
        push_seq(3'd5, 1'b0);
        req(3'd0);
        n = 0;
        while (!bus.pipe_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_start", 32'(n < 50), 32'd1);
        bus.current_mode = 3'd5;
        bus.mode_change  = 1'b1;
        @(negedge clk);
        bus.mode_change  = 1'b0;
        wait_idle("m5q");
        check("m5_mode", bus.active_mode, 3'd5);

        // Same mode again re-sequences fully.
        push_seq(3'd5, 1'b0);
        req(3'd5);
        wait_idle("m5re");

        // Reset during CLR_WAIT, then boot again.
        bus.clr_done = 1'b0;
        push_seq(3'd3, 1'b0);
        req(3'd3);
        n = 0;
        while (!bus.buf_clr && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("in_clr_wait", {bus.pipe_halt, bus.buf_clr, bus.cfg_we},
              {1'b1, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(all_outs()), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        bus.clr_done = 1'b1;
        push_seq(3'd0, 1'b0);
        rst_n = 1'b1;
        wait_idle("reboot");
        check("reboot_mode", bus.active_mode, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
